// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder and the hazard unit's stall logic.
// Latency: n/a. Backpressure: n/a.
package dmem_responder_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_responder_array.sv
// DEPTH x 32 word array: combinational read, write on the rising edge.
// Latency: read 0 cycles, write 1 edge. Backpressure: none.
module dmem_responder_array #(
    parameter int DEPTH     = 4096,
    parameter int ADDR_W    = 12,
    parameter     INIT_FILE = "data.mem"
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage; completes LATENCY cycles after acceptance.
// Backpressure: mem_stall holds the pipeline from acceptance until the completion cycle.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH     = 4096,
    parameter int ADDR_W    = 12,
    parameter int LATENCY   = 2,
    parameter     INIT_FILE = "data.mem"
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] read_data,
    output logic        mem_stall,
    output logic        misaligned,
    output logic        out_of_rng
);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [31:0]        read_q;
    logic [31:0]        arr_rdata;
    logic [31:0]        rd_val;
    logic [ADDR_W-1:0]  idx;
    logic               req;
    logic               in_rng;
    logic               complete;
    logic               complete_rd;
    logic               arr_we;

    assign req    = mem_read | mem_write;
    assign idx    = address[ADDR_W+1:2];
    assign in_rng = (address[31:ADDR_W+2] == '0);

    // With zero latency the access finishes in the accepting cycle itself.
    assign complete    = (LATENCY == 0) ? ((state == S_IDLE) && req) : (state == S_DONE);
    assign complete_rd = complete && mem_read && !mem_write;
    // Request level is re-sampled at completion, so a dropped store is never written.
    assign arr_we      = complete && mem_write && in_rng && !reset;
    assign rd_val      = in_rng ? arr_rdata : 32'h0;

    assign mem_stall = (LATENCY != 0) && (((state == S_IDLE) && req) || (state == S_WAIT));
    assign read_data = complete_rd ? rd_val : read_q;

    dmem_responder_array #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clock (clock),
        .we    (arr_we),
        .idx   (idx),
        .wdata (write_data),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            read_q     <= '0;
            misaligned <= 1'b0;
            out_of_rng <= 1'b0;
        end else begin
            if (complete_rd) read_q <= rd_val;
            if (complete && req) begin
                if (address[1:0] != 2'b00) misaligned <= 1'b1;
                if (!in_rng)               out_of_rng <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (req && (LATENCY != 0)) begin
                        if (LATENCY == 1) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_WAIT;
                            count <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                // The cycle in which count reaches zero is the DONE cycle.
                S_WAIT: begin
                    count <= count - CNT_W'(1);
                    if (count <= CNT_W'(1)) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: index 0 is a LATENCY=2 build, index 1 a LATENCY=0 build.
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address    [2];
    logic [31:0] write_data [2];
    logic [31:0] read_data  [2];
    logic        mem_read   [2];
    logic        mem_write  [2];
    logic        mem_stall  [2];
    logic        misaligned [2];
    logic        out_of_rng [2];

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] model [int];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd [2];

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH(4096), .ADDR_W(12), .LATENCY(2), .INIT_FILE("")) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address[0]),
        .write_data (write_data[0]),
        .mem_read   (mem_read[0]),
        .mem_write  (mem_write[0]),
        .read_data  (read_data[0]),
        .mem_stall  (mem_stall[0]),
        .misaligned (misaligned[0]),
        .out_of_rng (out_of_rng[0])
    );

    dmem_responder #(.DEPTH(4096), .ADDR_W(12), .LATENCY(0), .INIT_FILE("")) dut0 (
        .clock      (clock),
        .reset      (reset),
        .address    (address[1]),
        .write_data (write_data[1]),
        .mem_read   (mem_read[1]),
        .mem_write  (mem_write[1]),
        .read_data  (read_data[1]),
        .mem_stall  (mem_stall[1]),
        .misaligned (misaligned[1]),
        .out_of_rng (out_of_rng[1])
    );

    // One access on port sel: expected load data is queued at drive time, popped at completion.
    task automatic access(input int sel, input logic wr, input logic rd,
                          input logic [31:0] addr, input logic [31:0] wd, input string name);
        int          lat;
        int          stalls;
        int          key;
        logic [31:0] exp;
        lat = (sel == 0) ? 2 : 0;
        key = sel * 4096 + int'(addr[13:2]);
        @(posedge clock); #1;
        address[sel]    = addr;
        write_data[sel] = wd;
        mem_write[sel]  = wr;
        mem_read[sel]   = rd;
        if (wr) begin
            if (addr[31:14] == 18'h0) model[key] = wd;
        end else if (rd) begin
            exp_q.push_back((addr[31:14] == 18'h0 && model.exists(key)) ? model[key] : 32'h0);
        end
        stalls = 0;
        @(negedge clock);
        if (lat > 0) begin
            compared++;
            if (read_data[sel] !== last_rd[sel]) begin
                mismatched++;
                $display("FAIL %s hold: read_data got %h expected %h", name, read_data[sel], last_rd[sel]);
            end
        end
        while (mem_stall[sel] === 1'b1 && stalls < 20) begin
            stalls++;
            @(negedge clock);
        end
        compared++;
        if (stalls != lat) begin
            mismatched++;
            $display("FAIL %s stall: got %0d cycles expected %0d", name, stalls, lat);
        end
        if (rd && !wr) begin
            exp = exp_q.pop_front();
            last_rd[sel] = exp;
            compared++;
            if (read_data[sel] !== exp) begin
                mismatched++;
                $display("FAIL %s data: got %h expected %h", name, read_data[sel], exp);
            end
        end
    endtask

    task automatic idle(input int sel);
        @(posedge clock); #1;
        mem_read[sel]  = 1'b0;
        mem_write[sel] = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            address[s] = '0; write_data[s] = '0; mem_read[s] = 1'b0; mem_write[s] = 1'b0;
            last_rd[s] = '0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            compared += 4;
            if (read_data[s] !== 32'h0) begin
                mismatched++; $display("FAIL reset_read_data[%0d]: got %h expected 0", s, read_data[s]);
            end
            if (mem_stall[s] !== 1'b0) begin
                mismatched++; $display("FAIL reset_stall[%0d]: got %b expected 0", s, mem_stall[s]);
            end
            if (misaligned[s] !== 1'b0) begin
                mismatched++; $display("FAIL reset_misaligned[%0d]: got %b expected 0", s, misaligned[s]);
            end
            if (out_of_rng[s] !== 1'b0) begin
                mismatched++; $display("FAIL reset_out_of_rng[%0d]: got %b expected 0", s, out_of_rng[s]);
            end
        end
    endtask

    task automatic test_store_load;
        access(0, 1'b1, 1'b0, 32'h0000_0000, 32'hA5A5_0000, "store0");
        idle(0);
        access(0, 1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, "store40");
        idle(0);
        access(0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, "load40");
        idle(0);
        @(negedge clock);
        compared += 2;
        if (read_data[0] !== 32'h1234_5678) begin
            mismatched++; $display("FAIL load40_mirror: got %h expected 12345678", read_data[0]);
        end
        if (misaligned[0] !== 1'b0) begin
            mismatched++; $display("FAIL aligned_flag: got %b expected 0", misaligned[0]);
        end
    endtask

    task automatic test_misaligned;
        access(0, 1'b0, 1'b1, 32'h0000_0041, 32'h0, "load41");
        idle(0);
        @(negedge clock);
        compared++;
        if (misaligned[0] !== 1'b1) begin
            mismatched++; $display("FAIL misaligned_set: got %b expected 1", misaligned[0]);
        end
        access(0, 1'b1, 1'b0, 32'h0000_0044, 32'h0BAD_F00D, "store44");
        idle(0);
        access(0, 1'b0, 1'b1, 32'h0000_0044, 32'h0, "load44");
        idle(0);
        @(negedge clock);
        compared += 2;
        if (misaligned[0] !== 1'b1) begin
            mismatched++; $display("FAIL misaligned_sticky: got %b expected 1", misaligned[0]);
        end
        if (out_of_rng[0] !== 1'b0) begin
            mismatched++; $display("FAIL out_of_rng_clear: got %b expected 0", out_of_rng[0]);
        end
    endtask

    task automatic test_out_of_range;
        access(0, 1'b1, 1'b0, 32'h0001_0000, 32'hFFFF_FFFF, "store_oor");
        idle(0);
        @(negedge clock);
        compared++;
        if (out_of_rng[0] !== 1'b1) begin
            mismatched++; $display("FAIL out_of_rng_set: got %b expected 1", out_of_rng[0]);
        end
        access(0, 1'b0, 1'b1, 32'h0001_0000, 32'h0, "load_oor");
        idle(0);
        access(0, 1'b0, 1'b1, 32'h0000_0000, 32'h0, "load0_unchanged");
        idle(0);
        @(negedge clock);
        compared++;
        if (out_of_rng[0] !== 1'b1) begin
            mismatched++; $display("FAIL out_of_rng_sticky: got %b expected 1", out_of_rng[0]);
        end
    endtask

    task automatic test_back_to_back;
        access(0, 1'b1, 1'b0, 32'h0000_0080, 32'h1111_2222, "b2b_store");
        access(0, 1'b0, 1'b1, 32'h0000_0080, 32'h0, "b2b_load");
        access(0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, "b2b_load2");
        idle(0);
    endtask

    task automatic test_reset_mid_wait;
        @(posedge clock); #1;
        address[0] = 32'h0000_0080; write_data[0] = 32'h9999_9999; mem_write[0] = 1'b1;
        @(negedge clock);
        compared++;
        if (mem_stall[0] !== 1'b1) begin
            mismatched++; $display("FAIL abort_accept_stall: got %b expected 1", mem_stall[0]);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        mem_write[0] = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clock);
        compared += 3;
        if (mem_stall[0] !== 1'b0) begin
            mismatched++; $display("FAIL abort_stall: got %b expected 0", mem_stall[0]);
        end
        if (misaligned[0] !== 1'b0) begin
            mismatched++; $display("FAIL abort_misaligned: got %b expected 0", misaligned[0]);
        end
        if (read_data[0] !== 32'h0) begin
            mismatched++; $display("FAIL abort_read_data: got %h expected 0", read_data[0]);
        end
        access(0, 1'b0, 1'b1, 32'h0000_0080, 32'h0, "load80_after_abort");
        idle(0);
    endtask

    task automatic test_latency_zero;
        access(1, 1'b1, 1'b0, 32'h0000_0000, 32'hCAFE_BABE, "l0_store");
        access(1, 1'b0, 1'b1, 32'h0000_0000, 32'h0, "l0_load");
        access(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0F0F_0F0F, "l0_store10");
        access(1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, "l0_load10");
        access(1, 1'b0, 1'b1, 32'h0000_0002, 32'h0, "l0_load2");
        idle(1);
        @(negedge clock);
        compared += 2;
        if (misaligned[1] !== 1'b1) begin
            mismatched++; $display("FAIL l0_misaligned: got %b expected 1", misaligned[1]);
        end
        if (read_data[1] !== 32'hCAFE_BABE) begin
            mismatched++; $display("FAIL l0_mirror: got %h expected cafebabe", read_data[1]);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_wait();
        test_latency_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
